// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: FSM states, operand
// slot indices, header bit positions and per-mode packet word counts.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMMIT,
        START,
        WAIT
    } state_t;

    localparam int unsigned NUM_OPS       = 5;
    localparam int unsigned OP_A          = 0;
    localparam int unsigned OP_B          = 1;
    localparam int unsigned OP_C          = 2;
    localparam int unsigned OP_D          = 3;
    localparam int unsigned OP_E          = 4;

    localparam int unsigned HDR_F_ADD_BIT = 0;

    localparam int unsigned WORDS_NORMAL  = 5;
    localparam int unsigned WORDS_ADD     = 3;

    // Operand counter width; wide enough to index every slot.
    localparam int unsigned CNT_W         = 3;

    // Map the running word count to an operand slot.
    // Normal mode fills a,b,c,d,e in order; add mode fills a,c,e.
    function automatic logic [CNT_W-1:0] slot_idx(input logic f_add,
                                                  input logic [CNT_W-1:0] cnt);
        slot_idx = f_add ? {cnt[CNT_W-2:0], 1'b0} : cnt;
    endfunction

endpackage

// File: rtl/alu_loader_timeout.sv
// Stall counter for the LOAD state. Counts cycles with incr set,
// returns to zero on clear, and flags expire combinationally on the
// cycle whose increment would bring the count to TIMEOUT_CYCLES.
module alu_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic incr,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (incr) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire = incr && !clear && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Stall count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// Operand feeder for the ALU operand register stage. Receives a header
// word then 5 (normal) or 3 (add mode) operand words, drives them with
// reg_en for one commit cycle, pulses alu_start and waits for alu_done.
// Optional LOAD stall timeout: define ALU_LOADER_TIMEOUT_EN.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned BUS_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [BUS_WIDTH-1:0]                in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [NUM_OPS-1:0][BUS_WIDTH-1:0]   ops,
    output logic [BUS_WIDTH-1:0]                op_e,
    output logic [NUM_OPS-1:0]                  reg_en,
    output logic                                f_add,
    output logic                                alu_start,
    input  logic                                alu_done,
    output logic                                busy,
    output logic                                err
);

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 f_add_q, f_add_d;
    logic [NUM_OPS-1:0][BUS_WIDTH-1:0]    hold_q, hold_d;
    logic [NUM_OPS-2:0][BUS_WIDTH-1:0]    opsr_q, opsr_d;
    logic [BUS_WIDTH-1:0]                 op_e_q, op_e_d;
    logic [NUM_OPS-1:0]                   reg_en_q, reg_en_d;
    logic                                 alu_start_q, alu_start_d;

    logic                                 xfer;
    logic                                 last_word;
    logic                                 expire;
    logic [CNT_W-1:0]                     slot;

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign xfer      = in_valid && in_ready;
    assign slot      = slot_idx(f_add_q, cnt_q);
    assign last_word = (cnt_q == (f_add_q ? CNT_W'(WORDS_ADD - 1)
                                          : CNT_W'(WORDS_NORMAL - 1)));

    assign ops       = {op_e_q, opsr_q};
    assign op_e      = op_e_q;
    assign reg_en    = reg_en_q;
    assign f_add     = f_add_q;
    assign alu_start = alu_start_q;

`ifdef ALU_LOADER_TIMEOUT_EN
    logic err_q, err_d;

    alu_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state_q != LOAD) || xfer),
        .incr   ((state_q == LOAD) && !xfer),
        .expire (expire)
    );

    // Timeout pulse follows the expiring stall cycle.
    always_comb begin
        err_d = expire;
    end

    // Error pulse register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    // Next-state, operand assembly and registered output decode.
    // Words collect in hold_q; ops/op_e only change on entry to COMMIT,
    // so an aborted packet leaves the previous operands intact.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f_add_d     = f_add_q;
        hold_d      = hold_q;
        opsr_d      = opsr_q;
        op_e_d      = op_e_q;
        reg_en_d    = '0;
        alu_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    f_add_d = in_data[HDR_F_ADD_BIT];
                    cnt_d   = '0;
                    hold_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    for (int unsigned i = 0; i < NUM_OPS; i++) begin
                        if (slot == CNT_W'(i)) begin
                            hold_d[i] = in_data;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d  = COMMIT;
                        reg_en_d = '1;
                        for (int unsigned i = 0; i < NUM_OPS - 1; i++) begin
                            opsr_d[i] = hold_d[i];
                        end
                        op_e_d = hold_d[OP_E];
                        if (f_add_q) begin
                            opsr_d[OP_B] = '0;
                            opsr_d[OP_D] = '0;
                        end
                    end
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                alu_start_d = 1'b1;
                state_d     = START;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f_add_q     <= 1'b0;
            hold_q      <= '0;
            opsr_q      <= '0;
            op_e_q      <= '0;
            reg_en_q    <= '0;
            alu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f_add_q     <= f_add_d;
            hold_q      <= hold_d;
            opsr_q      <= opsr_d;
            op_e_q      <= op_e_d;
            reg_en_q    <= reg_en_d;
            alu_start_q <= alu_start_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with hand-computed expectations.
// Covers the ALU_LOADER_TIMEOUT_EN path when that macro is defined.
module tb_alu_operand_loader;

    localparam int unsigned W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [W-1:0]       in_data;
    logic               in_valid;
    logic               in_ready;
    logic [4:0][W-1:0]  ops;
    logic [W-1:0]       op_e;
    logic [4:0]         reg_en;
    logic               f_add;
    logic               alu_start;
    logic               alu_done;
    logic               busy;
    logic               err;

    int n_cmp = 0;
    int n_bad = 0;

    logic mon_en = 1'b0;
    int   stray_pulses = 0;

    alu_operand_loader #(
        .BUS_WIDTH      (W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ops       (ops),
        .op_e      (op_e),
        .reg_en    (reg_en),
        .f_add     (f_add),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Count any commit or start pulse while an aborted packet is in flight.
    always @(negedge clk) begin
        if (mon_en && ((reg_en != 5'b0) || alu_start)) begin
            stray_pulses++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hEE;
    endtask

    // START cycle then acknowledge with a one-cycle alu_done.
    task automatic finish_alu(input string tag);
        tick();
        check({tag, "_start"}, alu_start, 1'b1);
        check({tag, "_start_regen"}, reg_en, 5'b0);
        tick();
        check({tag, "_wait_start"}, alu_start, 1'b0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check({tag, "_idle_ready"}, in_ready, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        alu_done = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_ops", ops, 40'h0);
        check("rst_op_e", op_e, 8'h00);
        check("rst_reg_en", reg_en, 5'b0);
        check("rst_f_add", f_add, 1'b0);
        check("rst_start", alu_start, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1'b1);

        // Normal packet, back-to-back
        send(8'h00);
        check("norm_busy", busy, 1'b1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("norm_load_regen", reg_en, 5'b0);
        send(8'h55);
        check("norm_regen", reg_en, 5'b11111);
        check("norm_ops", ops, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
        check("norm_op_e", op_e, 8'h55);
        check("norm_f_add", f_add, 1'b0);
        check("norm_commit_ready", in_ready, 1'b0);
        check("norm_commit_start", alu_start, 1'b0);
        tick();
        check("norm_start", alu_start, 1'b1);
        check("norm_start_regen", reg_en, 5'b0);
        check("norm_start_ops", ops, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
        tick();

        // Held off during WAIT with in_valid asserted
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int i = 0; i < 10; i++) begin
            check("hold_ready", in_ready, 1'b0);
            check("hold_busy", busy, 1'b1);
            tick();
        end
        check("hold_ops", ops, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("hold_release_ready", in_ready, 1'b1);
        check("hold_release_busy", busy, 1'b0);
        tick();
        in_valid = 1'b0;
        check("hdr_accept_busy", busy, 1'b1);
        check("hdr_accept_f_add", f_add, 1'b1);

        // Add packet
        send(8'h07); send(8'h09);
        check("add_load_regen", reg_en, 5'b0);
        send(8'h03);
        check("add_regen", reg_en, 5'b11111);
        check("add_ops", ops, {8'h03, 8'h00, 8'h09, 8'h00, 8'h07});
        check("add_op_e", op_e, 8'h03);
        check("add_f_add", f_add, 1'b1);
        finish_alu("add");

        // Backpressure: 2-cycle gaps between words
        send(8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(); tick();
            check("bp_gap_ready", in_ready, 1'b1);
            check("bp_gap_regen", reg_en, 5'b0);
            send(8'hA1 + 8'(i));
        end
        check("bp_regen", reg_en, 5'b11111);
        check("bp_ops", ops, {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1});
        check("bp_op_e", op_e, 8'hA5);
        check("bp_f_add", f_add, 1'b0);
        finish_alu("bp");

        // Reset mid-packet
        mon_en = 1'b1;
        send(8'h00); send(8'h5A); send(8'h6B);
        rst_n = 1'b0;
        tick();
        check("mid_rst_ops", ops, 40'h0);
        check("mid_rst_op_e", op_e, 8'h00);
        check("mid_rst_regen", reg_en, 5'b0);
        check("mid_rst_f_add", f_add, 1'b0);
        check("mid_rst_start", alu_start, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();
        mon_en = 1'b0;
        check("mid_rst_no_pulse", stray_pulses, 0);
        check("mid_rst_idle_ready", in_ready, 1'b1);

        // Recovery with an add packet
        send(8'h01); send(8'h01); send(8'h02); send(8'h03);
        check("recov_regen", reg_en, 5'b11111);
        check("recov_ops", ops, {8'h03, 8'h00, 8'h02, 8'h00, 8'h01});
        finish_alu("recov");

`ifdef ALU_LOADER_TIMEOUT_EN
        // Stall timeout: header plus one operand, then silence
        stray_pulses = 0;
        mon_en = 1'b1;
        send(8'h00); send(8'h77);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tmo_pre_err", err, 1'b0);
            check("tmo_pre_busy", busy, 1'b1);
        end
        tick();
        check("tmo_err", err, 1'b1);
        check("tmo_idle_busy", busy, 1'b0);
        check("tmo_idle_ready", in_ready, 1'b1);
        check("tmo_keep_ops", ops, {8'h03, 8'h00, 8'h02, 8'h00, 8'h01});
        tick();
        check("tmo_err_pulse", err, 1'b0);
        mon_en = 1'b0;
        check("tmo_no_pulse", stray_pulses, 0);

        send(8'h00);
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4); send(8'hC5);
        check("tmo_next_regen", reg_en, 5'b11111);
        check("tmo_next_ops", ops, {8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1});
        finish_alu("tmo_next");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
